// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables/flushes from load-use, redirect, fetch miss and data-memory freeze.
// Optional HAZARD_CTRL_PERF_EN macro adds saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  imem_ready,
  input  logic                  dmem_busy,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic                  ifid_flush,
  output logic                  idex_we,
  output logic                  idex_flush,
  output logic                  exmem_we,
  output logic                  memwb_we,
  output logic                  mem_timeout,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
);

  localparam logic [0:0]  RUN       = 1'b0;
  localparam logic [0:0]  MEM_WAIT  = 1'b1;
  localparam logic [15:0] TIMEOUT_V = 16'(MEM_TIMEOUT);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [0:0]  state;
  logic [15:0] wait_cnt;
  logic        load_use;
  logic        redirect;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));
  assign redirect = !dmem_busy && ex_branch_taken;

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_we    = 1'b1;
    idex_flush = 1'b0;
    exmem_we   = 1'b1;
    memwb_we   = 1'b1;
    if (dmem_busy) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_we    = 1'b0;
      idex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_we      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (dmem_busy) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        default: begin
          wait_cnt <= sat_inc16(wait_cnt);
          // sticky: the FSM keeps waiting, only the flag reports the overrun
          if (wait_cnt >= TIMEOUT_V) mem_timeout <= 1'b1;
          if (!dmem_busy) state <= RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we)   stall_cnt <= sat_inc32(stall_cnt);
      if (redirect) flush_cnt <= sat_inc32(flush_cnt);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_hazard_ctrl;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, imem_ready, dmem_busy;
  logic       pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
    .idex_flush(idex_flush), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  ctl;
    logic        tmo;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 0;

  // model state: consecutive busy cycles seen before the current one
  int          m_busy_run = 0;
  logic        m_tmo = 1'b0;
  logic [31:0] m_sc = '0, m_fc = '0;

  task automatic apply(input bit r, input bit busy, input bit br, input bit imem,
                       input bit mr, input int rd, input int rs1, input bit u1,
                       input int rs2, input bit u2);
    exp_t e;
    bit   lu;
    @(posedge clk); #1;
    rst = r; dmem_busy = busy; ex_branch_taken = br; imem_ready = imem;
    ex_mem_read = mr; ex_rd = 5'(rd); id_rs1 = 5'(rs1); id_use_rs1 = u1;
    id_rs2 = 5'(rs2); id_use_rs2 = u2;
    lu = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we}
    if (busy)      e.ctl = 7'b0000000;
    else if (br)   e.ctl = 7'b1111111;
    else if (lu)   e.ctl = 7'b0000111;
    else if (!imem) e.ctl = 7'b0111011;
    else           e.ctl = 7'b1101011;
    e.tmo = m_tmo; e.sc = m_sc; e.fc = m_fc;
    q.push_back(e);
    if (r) begin
      m_busy_run = 0; m_tmo = 1'b0; m_sc = '0; m_fc = '0;
    end else begin
      // in MEM_WAIT the wait counter equals the MEM_WAIT cycles already spent
      if (m_busy_run >= 1 && (m_busy_run - 1) >= T) m_tmo = 1'b1;
      m_busy_run = busy ? m_busy_run + 1 : 0;
`ifdef HAZARD_CTRL_PERF_EN
      if (!e.ctl[6] && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (!busy && br && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if ({pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we} !== e.ctl) begin
          miscompares++;
          $display("FAIL ctl @%0t: got %b want %b", $time,
                   {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we}, e.ctl);
        end
        if (mem_timeout !== e.tmo) begin
          miscompares++;
          $display("FAIL mem_timeout @%0t: got %b want %b", $time, mem_timeout, e.tmo);
        end
        if (stall_cnt !== e.sc) begin
          miscompares++;
          $display("FAIL stall_cnt @%0t: got %0d want %0d", $time, stall_cnt, e.sc);
        end
        if (flush_cnt !== e.fc) begin
          miscompares++;
          $display("FAIL flush_cnt @%0t: got %0d want %0d", $time, flush_cnt, e.fc);
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; dmem_busy = 0; ex_branch_taken = 0; imem_ready = 1; ex_mem_read = 0;
    ex_rd = '0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    repeat (2) @(posedge clk);
    apply(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    // load-use then bubble release
    apply(0, 0, 0, 1, 1, 5, 5, 1, 0, 0);
    apply(0, 0, 0, 1, 0, 5, 5, 1, 0, 0);
    apply(0, 0, 0, 1, 1, 7, 0, 0, 7, 1);
    // x0 and unused-source exemptions
    apply(0, 0, 0, 1, 1, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 1, 1, 5, 5, 0, 0, 0);
    // redirect overrides load-use
    apply(0, 0, 1, 1, 1, 5, 5, 1, 0, 0);
    // freeze with pending redirect
    repeat (3) apply(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    // fetch miss
    repeat (2) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // timeout, sticky through idle, cleared by reset
    repeat (10) apply(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);
    apply(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    // reset while frozen
    repeat (3) apply(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    apply(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    begin
      bit busy_s = 0;
      for (int i = 0; i < 3000; i++) begin
        int rd, rs1, rs2;
        if (busy_s) busy_s = ($urandom_range(0, 9) < 8);
        else        busy_s = ($urandom_range(0, 9) == 0);
        rd  = $urandom_range(0, 3);
        rs1 = $urandom_range(0, 3);
        rs2 = $urandom_range(0, 3);
        apply($urandom_range(0, 199) == 0, busy_s, $urandom_range(0, 5) == 0,
              $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, rd, rs1,
              $urandom_range(0, 1) == 1, rs2, $urandom_range(0, 1) == 1);
      end
    end
    @(negedge clk); #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
